// File: rtl/wbu_stage.sv
// Write-back stage: single-entry buffer between execute and the register file.
// Formats load data, selects the rd result and returns the next PC to fetch.
module wbu_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_dnpc,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic [1:0]            in_sel,
  input  logic [DATA_WIDTH-1:0] in_alu_res,
  input  logic [DATA_WIDTH-1:0] in_csr_rdata,
  input  logic [DATA_WIDTH-1:0] in_load_data,
  input  logic [2:0]            in_load_fmt,
  input  logic [1:0]            in_addr_lo,
  output logic                  rf_valid,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_dnpc,
  output logic                  hz_valid,
  output logic [ADDR_WIDTH-1:0] hz_rd,
  output logic [CNT_WIDTH-1:0]  retire_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] dnpc;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  rd_wen;
    logic [1:0]            sel;
    logic [DATA_WIDTH-1:0] alu;
    logic [DATA_WIDTH-1:0] csr;
    logic [DATA_WIDTH-1:0] ld;
    logic [2:0]            fmt;
    logic [1:0]            lo;
  } entry_t;

  state_t                state;
  state_t                state_nxt;
  entry_t                ent;
  logic                  full;
  logic                  accept;
  logic                  commit;
  logic                  wr_rd;
  logic [7:0]            ld_b;
  logic [15:0]           ld_h;
  logic [DATA_WIDTH-1:0] ld_fmt;
  logic [DATA_WIDTH-1:0] result;

  assign full = (state == FULL);

  // State register; reset drops any held entry
  always_ff @(posedge clock) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Next state: refill on accept, drain on commit without a new entry
  always_comb begin
    state_nxt = state;
    if (accept)      state_nxt = FULL;
    else if (commit) state_nxt = EMPTY;
  end

  // Handshakes; reset blocks both accept and commit in its cycle
  always_comb begin
    in_ready  = !reset && (!full || out_ready);
    out_valid = !reset && full;
    accept    = in_valid && in_ready;
    commit    = out_valid && out_ready;
  end

  // Entry capture; contents only matter while FULL
  always_ff @(posedge clock) begin
    if (accept) begin
      ent.pc     <= in_pc;
      ent.dnpc   <= in_dnpc;
      ent.rd     <= in_rd;
      ent.rd_wen <= in_rd_wen;
      ent.sel    <= in_sel;
      ent.alu    <= in_alu_res;
      ent.csr    <= in_csr_rdata;
      ent.ld     <= in_load_data;
      ent.fmt    <= in_load_fmt;
      ent.lo     <= in_addr_lo;
    end
  end

  // Load formatting: byte by addr_lo, halfword by addr_lo[1]
  always_comb begin
    ld_b = ent.ld[{ent.lo, 3'b000} +: 8];
    ld_h = ent.lo[1] ? ent.ld[31:16] : ent.ld[15:0];
    unique case (ent.fmt)
      3'b000:  ld_fmt = {{(DATA_WIDTH-8){ld_b[7]}}, ld_b};
      3'b001:  ld_fmt = {{(DATA_WIDTH-16){ld_h[15]}}, ld_h};
      3'b100:  ld_fmt = {{(DATA_WIDTH-8){1'b0}}, ld_b};
      3'b101:  ld_fmt = {{(DATA_WIDTH-16){1'b0}}, ld_h};
      default: ld_fmt = ent.ld;
    endcase
  end

  // Result select for rd
  always_comb begin
    unique case (ent.sel)
      2'd0:    result = ent.alu;
      2'd1:    result = ld_fmt;
      2'd2:    result = ent.pc + DATA_WIDTH'(4);
      default: result = ent.csr;
    endcase
  end

  // Write port and hazard view, all zero while EMPTY
  always_comb begin
    wr_rd    = full && ent.rd_wen && (ent.rd != '0);
    rf_valid = commit;
    rf_wen   = wr_rd;
    rf_waddr = full ? ent.rd : '0;
    rf_wdata = full ? result : '0;
    out_dnpc = full ? ent.dnpc : '0;
    hz_valid = wr_rd;
    hz_rd    = wr_rd ? ent.rd : '0;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clock) begin
    if (reset)       retire_cnt <= '0;
    else if (commit) retire_cnt <= retire_cnt + CNT_WIDTH'(1);
  end

endmodule
